// File: rtl/mux_stream_nto1_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_stream_nto1_if
//  Description : Stream bundle for the N-to-1 stream multiplexer. It carries the
//                N producer channels in and the single registered channel out.
//                The master modport is the environment side; the slave modport
//                is the multiplexer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface mux_stream_nto1_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_ch;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_stream_nto1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_stream_nto1
//  Description : Registered N-to-1 stream multiplexer. A channel is picked by an
//                explicit select code (mode=0) or by round-robin search
//                (mode=1); the granted beat is stored in a one-entry output
//                register with valid/ready flow control.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_stream_nto1 #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             mode,
    input  wire logic [SEL_W-1:0] sel,
    mux_stream_nto1_if.slave      bus
);

    localparam logic [SEL_W:0]   C_N_WIDE = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] C_LAST   = SEL_W'(N - 1);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_can_accept;
    logic             w_grant_vld;
    logic [SEL_W-1:0] w_grant;
    logic [SEL_W:0]   w_idx;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_xfer;

    // The output register can take a beat when empty or being drained now.
    assign w_can_accept = !r_out_valid || bus.out_ready;

    // Pick the granted channel: fixed select, or first valid at/after rr_ptr.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_idx       = '0;
        if (!mode) begin
            // Loop over real channels only, so an out-of-range sel never grants.
            for (int i = 0; i < N; i++) begin
                if (sel == SEL_W'(i) && bus.in_valid[i]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                // rr_ptr < N, so one conditional subtract gives the modulo-N wrap.
                w_idx = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
                if (w_idx >= C_N_WIDE) begin
                    w_idx = w_idx - C_N_WIDE;
                end
                if (!w_grant_vld && bus.in_valid[w_idx[SEL_W-1:0]]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = w_idx[SEL_W-1:0];
                end
            end
        end
    end

    // Route the granted channel's data toward the output register.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A grant is only issued to a valid channel, so a grant here means a transfer.
    assign w_xfer = w_can_accept && w_grant_vld;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign bus.in_ready[gi] = w_xfer && (w_grant == SEL_W'(gi));
        end
    endgenerate

    // Output register and round-robin pointer. A drain and a load in the same
    // cycle replace the beat with no bubble; a pure drain keeps the data/channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_sel_data;
                r_out_ch    <= w_grant;
                r_out_valid <= 1'b1;
                if (mode) begin
                    r_rr_ptr <= (w_grant == C_LAST) ? '0 : w_grant + 1'b1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_stream_nto1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_stream_nto1
//  Description : Directed bench for mux_stream_nto1 (N=4 main instance with a
//                cycle-by-cycle reference model, plus an N=3 instance for the
//                out-of-range select and non-power-of-two wrap).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux_stream_nto1;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int N3    = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode;
    logic [1:0] sel;
    logic       mode3;
    logic [1:0] sel3;

    int total = 0;
    int bad   = 0;

    mux_stream_nto1_if #(.WIDTH(WIDTH), .N(N))  bus  ();
    mux_stream_nto1_if #(.WIDTH(WIDTH), .N(N3)) bus3 ();

    mux_stream_nto1 #(.WIDTH(WIDTH), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus)
    );

    mux_stream_nto1 #(.WIDTH(WIDTH), .N(N3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode3),
        .sel   (sel3),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change 2 time units after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // ---------------- reference model of the N=4 instance ----------------
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;

    // Grant from the selection rules: -1 when nobody is granted.
    function automatic int exp_grant();
        if (!mode) begin
            if (int'(sel) < N && bus.in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            if (bus.in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_ch    <= 0;
            m_ptr   <= 0;
        end else begin
            g = exp_grant();
            if ((!m_valid || bus.out_ready) && g >= 0) begin
                m_valid <= 1'b1;
                m_data  <= bus.in_data[g*WIDTH +: WIDTH];
                m_ch    <= g;
                if (mode) m_ptr <= (g + 1) % N;
            end else if (m_valid && bus.out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare the N=4 instance against the model every falling edge.
    always @(negedge clk) begin
        int         g;
        logic [3:0] em;
        g  = exp_grant();
        em = '0;
        if ((!m_valid || bus.out_ready) && g >= 0) em[g] = 1'b1;
        chk("cmp_in_ready",  32'(bus.in_ready),  32'(em));
        chk("cmp_out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("cmp_out_data",  32'(bus.out_data),  32'(m_data));
        chk("cmp_out_ch",    32'(bus.out_ch),    32'(m_ch));
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        bus.in_data    = 32'h44A52211;   // ch3=44 ch2=A5 ch1=22 ch0=11
        bus.in_valid   = 4'b0000;
        bus.out_ready  = 1'b0;
        mode           = 1'b0;
        sel            = 2'd0;
        bus3.in_data   = 24'hCCBBAA;
        bus3.in_valid  = 3'b000;
        bus3.out_ready = 1'b1;
        mode3          = 1'b0;
        sel3           = 2'd0;

        cyc();
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_data",  32'(bus.out_data),  32'd0);
        chk("reset_out_ch",    32'(bus.out_ch),    32'd0);
        cyc();
        rst_n = 1'b1;

        // Fixed select of channel 2 with every channel valid.
        mode = 1'b0; sel = 2'd2; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        #1 chk("fixed_in_ready", 32'(bus.in_ready), 32'h4);
        cyc();
        chk("fixed_out_data",  32'(bus.out_data),  32'hA5);
        chk("fixed_out_ch",    32'(bus.out_ch),    32'd2);
        chk("fixed_out_valid", 32'(bus.out_valid), 32'd1);

        // Backpressure: held beat stays put while mode/sel/data move around.
        bus.out_ready = 1'b0;
        bus.in_data[15:8] = 8'h77;
        for (int i = 0; i < 3; i++) begin
            mode = (i == 1);
            sel  = 2'(i);
            bus.in_data[31:24] = 8'h90 + 8'(i);
            #1 chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            cyc();
            chk("bp_out_data", 32'(bus.out_data), 32'hA5);
            chk("bp_out_ch",   32'(bus.out_ch),   32'd2);
        end
        mode = 1'b0; sel = 2'd1; bus.out_ready = 1'b1;
        #1 chk("bp_release_in_ready", 32'(bus.in_ready), 32'h2);
        cyc();
        chk("bp_release_data",  32'(bus.out_data),  32'h77);
        chk("bp_release_ch",    32'(bus.out_ch),    32'd1);
        chk("bp_release_valid", 32'(bus.out_valid), 32'd1);

        // Round-robin fairness, all valid: 0,1,2,3,0,1,2,3.
        mode = 1'b1; bus.in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("rr_all_ch", 32'(bus.out_ch), 32'(i % 4));
        end
        // Sparse valids 1010: 1,3,1,3.
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_sparse_ch", 32'(bus.out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Wrap/skip: grant ch2 moves the pointer to 3, then only ch0 is valid.
        bus.in_valid = 4'b0100;
        cyc();
        chk("rr_to3_ch", 32'(bus.out_ch), 32'd2);
        bus.in_valid = 4'b0001;
        #1 chk("rr_wrap_in_ready", 32'(bus.in_ready), 32'h1);
        cyc();
        chk("rr_wrap_ch", 32'(bus.out_ch), 32'd0);
        #1 chk("rr_skip_in_ready", 32'(bus.in_ready), 32'h1);
        cyc();
        chk("rr_skip_ch", 32'(bus.out_ch), 32'd0);

        // Pure drain: valid drops, data/channel hold.
        bus.in_valid = 4'b0000;
        cyc();
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_data",  32'(bus.out_data),  32'h11);
        chk("drain_ch",    32'(bus.out_ch),    32'd0);

        // Reset in the middle of a held beat.
        mode = 1'b0; sel = 2'd3; bus.in_valid = 4'b1111;
        cyc();
        chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_reset_data",  32'(bus.out_data),  32'h92);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(bus.out_valid), 32'd0);
        chk("async_reset_data",  32'(bus.out_data),  32'd0);
        chk("async_reset_ch",    32'(bus.out_ch),    32'd0);
        bus.in_valid = 4'b0000;
        cyc();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
        chk("post_reset_valid0", 32'(bus.out_valid), 32'd0);
        cyc();
        chk("post_reset_valid1", 32'(bus.out_valid), 32'd0);

        // N=3: sel=3 is out of range and must never grant.
        mode3 = 1'b0; sel3 = 2'd3; bus3.in_valid = 3'b111;
        #1 chk("n3_oor_in_ready", 32'(bus3.in_ready), 32'd0);
        cyc();
        chk("n3_oor_valid0", 32'(bus3.out_valid), 32'd0);
        cyc();
        chk("n3_oor_valid1", 32'(bus3.out_valid), 32'd0);
        sel3 = 2'd2;
        #1 chk("n3_sel2_in_ready", 32'(bus3.in_ready), 32'h4);
        cyc();
        chk("n3_sel2_ch",   32'(bus3.out_ch),   32'd2);
        chk("n3_sel2_data", 32'(bus3.out_data), 32'hCC);
        // N=3 round-robin wraps 2 -> 0.
        mode3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("n3_rr_ch", 32'(bus3.out_ch), 32'(i % 3));
        end

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_stream_nto1.md
# mux_stream_nto1

Parametrised N-to-1 stream multiplexer: the registered, handshaked successor to the team's combinational 2:1 mux. It selects one of N input channels, either by an explicit select code or by round-robin arbitration, and forwards one beat per cycle through a single output register with valid/ready flow control. It sits between multiple producer blocks and a single shared consumer in the lab datapath.

## Interface
- WIDTH, 8, data width per channel (≥1)
- N, 4, number of input channels (2..16)
- SEL_W, $clog2(N), select/channel-index width (derived; do not override)

- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel index used when mode=0
- out_data  output  WIDTH  registered output data
- out_ch  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  registered output valid
- out_ready  input  1  consumer ready

## Operation
- Output stage: one-entry register {out_data, out_ch, out_valid}.
- can_accept = !out_valid | out_ready (empty, or draining this cycle).
- Grant (combinational, each cycle):
  - mode=0: grant = sel if sel < N and in_valid[sel]; else no grant. sel ≥ N never grants.
  - mode=1: search from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1); first channel with in_valid set wins.
- in_ready[i] = can_accept & grant valid & (grant == i). At most one bit of in_ready is high; all zero when no grant.
- Transfer on channel i when in_valid[i] & in_ready[i]: register loads out_data = channel i data, out_ch = i, out_valid = 1.
- If out_valid & out_ready and no input transfer: out_valid -> 0; out_data/out_ch hold their last values.
- Simultaneous drain and load: new beat replaces old in the same edge; no bubble.
- rr_ptr (SEL_W bits, internal): on any transfer in mode=1, rr_ptr <= grant+1, wrapping N-1 -> 0 (also correct for non-power-of-two N). In mode=0 rr_ptr holds.
- mode and sel are sampled every cycle; changing them while out_valid=1 does not disturb the held beat.
- out_data/out_ch must stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready then reads as 0 only if no grant; with out_valid=0, in_ready follows grant immediately after reset release.
- Reset mid-transfer: held beat discarded, no output on release.
- Latency: input transfer at edge k -> out_valid=1 with data visible after edge k.
- Throughput: 1 beat/cycle with out_ready held high.
- in_ready depends combinationally on in_valid, mode, sel, out_valid, out_ready, rr_ptr; no combinational path from in_data to any output.

## Test plan
- Reset: drive rst_n=0 mid-simulation with out_valid=1 -> out_valid, out_data, out_ch all 0 immediately, before next clk edge; no beat emerges after release.
- Fixed mode, WIDTH=8, N=4: mode=0, sel=2, in_data ch2=8'hA5, all in_valid=4'b1111, out_ready=1 -> only in_ready[2]=1; next cycle out_data=8'hA5, out_ch=2, out_valid=1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while inputs change -> in_ready=0, out_data/out_ch unchanged; out_ready=1 -> new beat loads same edge, no idle cycle.
- Round-robin fairness: mode=1, all in_valid=1, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3; with in_valid=4'b1010 -> 1,3,1,3.
- Round-robin wrap/skip: rr_ptr=3, in_valid=4'b0001 -> grants ch0, rr_ptr becomes 1; then in_valid=4'b0001 still -> grants ch0.
- Out-of-range select with N=3 (SEL_W=2): mode=0, sel=3, all valid -> in_ready=3'b000, out_valid stays 0.
